// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: data/control widths, opcode
// values and the multiply FSM state type.
package exec_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] OP_ADD  = 4'd0;
  localparam logic [CTRL_W-1:0] OP_SUB  = 4'd1;
  localparam logic [CTRL_W-1:0] OP_AND  = 4'd2;
  localparam logic [CTRL_W-1:0] OP_OR   = 4'd3;
  localparam logic [CTRL_W-1:0] OP_XOR  = 4'd4;
  localparam logic [CTRL_W-1:0] OP_SHL  = 4'd5;
  localparam logic [CTRL_W-1:0] OP_SHR  = 4'd6;
  localparam logic [CTRL_W-1:0] OP_LI   = 4'd7;
  localparam logic [CTRL_W-1:0] OP_ADDI = 4'd8;
  localparam logic [CTRL_W-1:0] OP_MUL  = 4'd9;
  localparam logic [CTRL_W-1:0] OP_SLT  = 4'd10;
  localparam logic [CTRL_W-1:0] OP_NOP  = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/exec_stage_alu.sv
// exec_alu: purely combinational single-cycle ALU of the execute stage.
// Ports:
//   a, b   : operands A and B
//   imm    : immediate operand (LI, ADDI)
//   ctrl   : opcode
//   result : modulo-2^16 result; 0 for MUL and the NOP codes
module exec_alu
  import exec_stage_pkg::*;
#(
  parameter int S = 15,
  parameter int C = 3
) (
  input  logic [S:0] a,
  input  logic [S:0] b,
  input  logic [S:0] imm,
  input  logic [C:0] ctrl,
  output logic [S:0] result
);

  always_comb begin
    result = '0;
    case (ctrl)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[3:0];
      OP_SHR:  result = a >> b[3:0];
      OP_LI:   result = imm;
      OP_ADDI: result = a + imm;
      OP_SLT:  result = {{S{1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage between the ID/EX and EX/MEM buffers.
// Single-cycle ALU ops go through exec_alu; MUL runs a 16-step shift-add
// sequence and holds the ID/EX buffer via Stall while it iterates.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   InValid    : inputs carry a real instruction
//   InData1/2  : operands A and B (B is also store data)
//   InData15   : immediate operand
//   InCtrl     : opcode
//   Flush      : kill the in-flight instruction
//   Stall      : combinational hold request to the ID/EX buffer
//   OutResult, OutStore, OutCtrl, OutValid, OutZero : registered outputs
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int S = 15,
  parameter int C = 3,
  parameter int M = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       InValid,
  input  logic [S:0] InData1,
  input  logic [S:0] InData2,
  input  logic [S:0] InData15,
  input  logic [C:0] InCtrl,
  input  logic       Flush,
  output logic       Stall,
  output logic [S:0] OutResult,
  output logic [S:0] OutStore,
  output logic [C:0] OutCtrl,
  output logic       OutValid,
  output logic       OutZero
);

  localparam int CNTW = $clog2(M);

  state_t          state;
  logic [S:0]      ash;
  logic [S:0]      bsh;
  logic [S:0]      acc;
  logic [S:0]      mul_store;
  logic [C:0]      mul_ctrl;
  logic [CNTW-1:0] cnt;

  logic [S:0] alu_res;
  logic [S:0] acc_next;
  logic       accept_mul;
  logic       last_iter;

  exec_alu #(
    .S(S),
    .C(C)
  ) u_alu (
    .a     (InData1),
    .b     (InData2),
    .imm   (InData15),
    .ctrl  (InCtrl),
    .result(alu_res)
  );

  always_comb begin
    accept_mul = (state == ST_IDLE) && InValid && (InCtrl == OP_MUL);
    acc_next   = acc + (bsh[0] ? ash : '0);
    last_iter  = (cnt == CNTW'(M - 1));
    // Reset and Flush both force Stall low so the upstream buffer can move.
    Stall      = rst && !Flush && ((state == ST_MUL) || accept_mul);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ash       <= '0;
      bsh       <= '0;
      acc       <= '0;
      mul_store <= '0;
      mul_ctrl  <= '0;
      cnt       <= '0;
      OutResult <= '0;
      OutStore  <= '0;
      OutCtrl   <= '0;
      OutValid  <= 1'b0;
      OutZero   <= 1'b0;
    end else if (Flush) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      OutValid <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept_mul) begin
        ash       <= InData1;
        bsh       <= InData2;
        acc       <= '0;
        cnt       <= '0;
        mul_store <= InData2;
        mul_ctrl  <= InCtrl;
        OutValid  <= 1'b0;
        state     <= ST_MUL;
      end else begin
        OutResult <= alu_res;
        OutZero   <= (alu_res == '0);
        OutStore  <= InData2;
        OutCtrl   <= InCtrl;
        OutValid  <= InValid;
      end
    end else begin
      acc      <= acc_next;
      ash      <= ash << 1;
      bsh      <= bsh >> 1;
      cnt      <= cnt + CNTW'(1);
      OutValid <= 1'b0;
      // The final add is folded into the output load, so the product
      // leaves on the same edge as the last iteration.
      if (last_iter) begin
        OutResult <= acc_next;
        OutZero   <= (acc_next == '0);
        OutStore  <= mul_store;
        OutCtrl   <= mul_ctrl;
        OutValid  <= 1'b1;
        cnt       <= '0;
        state     <= ST_IDLE;
      end
    end
  end

endmodule
